memory_read_demux: RTL
======================

# memory_read_demux

- Read-side counterpart to the systolic-array result writer: on `init`, walks a 45-entry location table and fetches one 32-bit word per entry from the shared result memory.
- Distributes the fetched words round-robin across five output lanes, one-hot write enable per lane, feeding the five per-row input FIFOs of the array.
- Supports per-lane backpressure, padding entries, and a one-cycle completion pulse.

## Interface
Parameters:
- `N`, 32, data word width.
- `W`, 8, memory address width.
- `ROW`, 5, row stride used in location-to-index conversion.
- `COUNT`, 45, table entries walked per pass; lanes are fixed at 5.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `init` input 1: start request, sampled only in IDLE.
- `base_address` input 8: added to every computed index; sampled at start.
- `loc_wr_en` input 1: location table write strobe.
- `loc_wr_addr` input 6: location table write address.
- `loc_wr_data` input 8: location entry, {row[7:4], col[3:0]}; 8'hFF = padding.
- `mem_addr` output W: memory read address.
- `mem_rd_en` output 1: memory read strobe.
- `mem_rd_data` input N: memory read data, valid the cycle after `mem_rd_en`.
- `lane_full` input 5: per-lane full flag from the downstream FIFO.
- `data_out` output N: word presented to the lanes.
- `wr_en` output 5: one-hot lane write enable.
- `busy` output 1: high from the cycle after accepted `init` until the pass finishes.
- `com` output 1: one-cycle pulse when the pass completes.

## Operation
- Table: 64×8 RAM, written synchronously via `loc_*` at any time; contents are not cleared by `rst`. A same-cycle read of a written address returns the old value.
- Counters:
  - `entry` runs 0..COUNT-1.
  - `lane` runs 0..4 and wraps to 0.
  - Both are zeroed at start.
- FSM states: IDLE, LOOKUP, READ, CAPTURE, WRITE.
- IDLE -> LOOKUP when `init`=1; latch `base_address`, clear counters. `init` is ignored in every other state.
- LOOKUP: register `table[entry]` into `loc_q`. Next state is READ.
- READ:
  - Drive `mem_rd_en`=1 and `mem_addr` = (base + loc_q[7:4]*ROW + loc_q[3:0]) mod 2^W; the multiply is carried in 8 bits, then truncated.
  - If `loc_q`=8'hFF, drive `mem_rd_en`=0 (no read issued).
  - Next state is CAPTURE.
- CAPTURE: `data_out` <= `mem_rd_data`, or 0 when `loc_q`=8'hFF. Next state is WRITE.
- WRITE:
  - `wr_en[lane]` = !`lane_full[lane]` (combinational). While full, stay in WRITE with `data_out` held and `wr_en`=0.
  - On the write cycle, `lane` advances with wrap.
  - If `entry`=COUNT-1, go to IDLE and pulse `com`. Otherwise `entry`+1 and go to LOOKUP.
- `lane_full` bits of non-selected lanes are ignored.
- `rst` at any time: state IDLE, counters 0, all outputs 0 on the next cycle. A pass in progress is abandoned without `com`.

## Timing
- Reset values: `mem_addr`=0, `mem_rd_en`=0, `data_out`=0, `wr_en`=0, `busy`=0, `com`=0.
- Minimum 4 cycles per entry, with no backpressure:
  - LOOKUP at t+1 after `init` at t.
  - READ at t+2.
  - CAPTURE at t+3.
  - WRITE at t+4.
- Full pass takes 180 cycles minimum. `com`=1 and `busy`=0 in the cycle after the last WRITE.
- `init` held high through `com` starts a new pass in the cycle after `com` (IDLE samples it).
- `busy` and `com` are never high in the same cycle.

## Configuration
- `MEM_READ_SKIP_PAD_EN`:
  - Defined: an 8'hFF entry issues no read and produces no lane write; `lane` does not advance; the FSM goes from CAPTURE directly to the next LOOKUP (or to IDLE plus `com` if last).
  - Undefined: an 8'hFF entry writes a zero word to the current lane and `lane` advances, as in Operation.

## Test plan
- Load table[i] = {i/5, i%5}, base=0x10, mem[k]=k; pulse `init`:
  - Lane j receives 9 words 0x10+j, 0x15+j, ….
  - `com` pulses once, 180 cycles after `init`.
- Hold `lane_full[2]`=1 for 10 cycles during entry 2's WRITE:
  - `wr_en`=0 and `data_out`=0x12 stable throughout.
  - Write occurs on the release cycle; total pass is 190 cycles.
- Table[7]=0xFF, macro undefined: no `mem_rd_en` for entry 7; lane 2 receives 0x00000000. Macro defined: entry 8 lands on lane 2.
- base=0xF0, table[0]=0x32: `mem_addr`=0x01 (0xF0+17 wraps).
- Assert `rst` during entry 20: next cycle all outputs are 0 and no `com` fires. New `init` restarts at entry 0, lane 0, with table contents intact.
- Pulse `init` while `busy`: no effect on sequence or timing. `loc_wr_en` to entry 30 during entry 10 is used for entry 30 of the same pass.

Source files
------------

// File: rtl/memory_read_demux.sv
// Read-side demux: walks a 45-entry location table, fetches one word per entry and deals the
// words round-robin onto five FIFO lanes. Define MEM_READ_SKIP_PAD_EN to drop padding entries.
module memory_read_demux #(
    parameter int N     = 32,
    parameter int W     = 8,
    parameter int ROW   = 5,
    parameter int COUNT = 45
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic [W-1:0] base_address,
    input  logic         loc_wr_en,
    input  logic [5:0]   loc_wr_addr,
    input  logic [7:0]   loc_wr_data,
    output logic [W-1:0] mem_addr,
    output logic         mem_rd_en,
    input  logic [N-1:0] mem_rd_data,
    input  logic [4:0]   lane_full,
    output logic [N-1:0] data_out,
    output logic [4:0]   wr_en,
    output logic         busy,
    output logic         com
);
    typedef enum logic [2:0] {IDLE, LOOKUP, READ, CAPTURE, WRITE} state_t;

    localparam logic [7:0] PAD  = 8'hFF;
    localparam logic [7:0] ROW8 = 8'(ROW);
    localparam logic [5:0] LAST = 6'(COUNT - 1);

    state_t       r_state;
    logic [7:0]   r_table [64];
    logic [5:0]   r_entry;
    logic [2:0]   r_lane;
    logic [W-1:0] r_base;
    logic [7:0]   r_loc_q;
    logic [W-1:0] r_mem_addr;
    logic         r_mem_rd_en;
    logic [N-1:0] r_data_out;
    logic         r_busy;
    logic         r_com;

    logic [7:0]   w_loc;
    logic [7:0]   w_prod;
    logic [W-1:0] w_addr;
    logic         w_lane_ready;
    logic         w_last;

    // Table survives reset; a same-cycle read sees the previous contents.
    always_ff @(posedge clk) begin
        if (loc_wr_en) r_table[loc_wr_addr] <= loc_wr_data;
    end

    assign w_loc        = r_table[r_entry];
    assign w_prod       = {4'd0, w_loc[7:4]} * ROW8;
    assign w_addr       = r_base + W'(w_prod) + W'({4'd0, w_loc[3:0]});
    assign w_lane_ready = !lane_full[r_lane];
    assign w_last       = (r_entry == LAST);

    assign wr_en     = (r_state == WRITE && w_lane_ready) ? (5'b00001 << r_lane) : 5'b00000;
    assign mem_addr  = r_mem_addr;
    assign mem_rd_en = r_mem_rd_en;
    assign data_out  = r_data_out;
    assign busy      = r_busy;
    assign com       = r_com;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_entry     <= '0;
            r_lane      <= '0;
            r_base      <= '0;
            r_loc_q     <= '0;
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
            r_data_out  <= '0;
            r_busy      <= 1'b0;
            r_com       <= 1'b0;
        end else begin
            r_com <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (init) begin
                        r_base  <= base_address;
                        r_entry <= '0;
                        r_lane  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Address is registered here so it is stable for the whole READ cycle.
                    r_loc_q     <= w_loc;
                    r_mem_addr  <= w_addr;
                    r_mem_rd_en <= (w_loc != PAD);
                    r_state     <= READ;
                end
                READ: begin
                    r_mem_rd_en <= 1'b0;
                    r_state     <= CAPTURE;
                end
                CAPTURE: begin
`ifdef MEM_READ_SKIP_PAD_EN
                    if (r_loc_q == PAD) begin
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_com   <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_entry <= r_entry + 6'd1;
                            r_state <= LOOKUP;
                        end
                    end else begin
                        r_data_out <= mem_rd_data;
                        r_state    <= WRITE;
                    end
`else
                    r_data_out <= (r_loc_q == PAD) ? '0 : mem_rd_data;
                    r_state    <= WRITE;
`endif
                end
                WRITE: begin
                    if (w_lane_ready) begin
                        r_lane <= (r_lane == 3'd4) ? 3'd0 : r_lane + 3'd1;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_com   <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_entry <= r_entry + 6'd1;
                            r_state <= LOOKUP;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
